bt_uart_tx: RTL

- Serial UART transmitter feeding the Bluetooth module's `rx` line (HC-05 class link).
- The host side writes bytes into a small internal FIFO.
- The block serialises each byte as 8N1: start bit, 8 data bits LSB first, stop bit, at a programmable bit period.
- It is the transmit counterpart of the existing `bluetooth` receive path and replaces bench-driven `rx` stimulus in system builds.

---
 rtl/bt_uart_tx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bt_uart_tx.sv
// rtl/bt_uart_tx.sv - FIFO-fed 8N1 UART transmitter for the Bluetooth module rx line.
// Optional even parity bit between data and stop when BT_UART_TX_PARITY_EN is defined.
module bt_uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef BT_UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  logic [7:0]         mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push, pop;

  state_t      state, state_d;
  logic [15:0] baud, baud_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift, shift_d;
  logic        tx_d, busy_d, done_d;
`ifdef BT_UART_TX_PARITY_EN
  logic        par, par_d;
`endif

  // count only reaches 2**FIFO_AW when full, so its MSB is the full flag
  assign full  = count[FIFO_AW];
  assign empty = (count == '0);
  assign push  = wr_en & ~full;
  assign pop   = (state == IDLE) & ~empty;

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    tx_d      = tx;
    busy_d    = busy;
    done_d    = 1'b0;
`ifdef BT_UART_TX_PARITY_EN
    par_d     = par;
`endif
    case (state)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        if (!empty) begin
          shift_d = mem[rd_ptr];
`ifdef BT_UART_TX_PARITY_EN
          par_d   = ^mem[rd_ptr];
`endif
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_d    = '0;
          tx_d      = shift[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud + 16'd1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef BT_UART_TX_PARITY_EN
            tx_d    = par;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // next bit goes on the line as the register shifts
            shift_d   = {1'b0, shift[7:1]};
            tx_d      = shift[1];
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_d = baud + 16'd1;
        end
      end
`ifdef BT_UART_TX_PARITY_EN
      PARITY: begin
        if (baud == BAUD_LAST) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud + 16'd1;
        end
      end
`endif
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef BT_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef BT_UART_TX_PARITY_EN
      par     <= par_d;
`endif
    end
  end

endmodule
